// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and the cpu-side decode.
// Holds the FSM encoding, the line count and the default vector table placement.
package int_ctrl_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W = $clog2(NUM_IRQ);
  localparam logic [9:0] VEC_BASE_DFLT = 10'h3C0;
  localparam int VEC_STRIDE_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Fixed priority: the lowest set index wins.
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    lowest_set = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line optional synchronizer plus rising-edge detector with a registered one-cycle event.
// Latency: event is visible one cycle after the edge is sampled, plus one cycle per sync stage.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic evt
);

  logic synced;
  logic hist_q, hist_d;
  logic evt_q, evt_d;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d = SYNC_STAGES'({sync_q, line});
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign synced = line;
    end
  endgenerate

  always_comb begin
    hist_d = synced;
    evt_d  = synced & ~hist_q;
  end

  // History clears to 0 so a line already high at reset release yields one event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      evt_q  <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: sticky pending bits, mask, fixed priority and a req/ack/ret handshake.
// Latency: sampled edge -> pending after +1 edge -> int_req after +2 edges (plus sync stages).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int                SYNC_STAGES = 0,
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(VEC_BASE_DFLT),
  parameter int                VEC_STRIDE  = VEC_STRIDE_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               int_ret,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [ADDR_W-1:0]  int_addr,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] overflow
);

  logic [NUM_IRQ-1:0] evt;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] ovf_q, ovf_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] ack_clr;

  state_t          state_q;
  logic            int_req_q;
  logic            in_service_q;
  logic [ID_W-1:0] int_id_q;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .line  (irq_in[i]),
      .evt   (evt[i])
    );
  end

  assign elig = pend_q & mask_q;

  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && int_ack) ack_clr[int_id_q] = 1'b1;
  end

  // An ack together with a fresh event keeps the line pending; an event on an
  // already-pending, un-acked line is lost and flagged instead.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_clr[i]) begin
        pend_d[i] = evt[i];
        ovf_d[i]  = 1'b0;
      end else begin
        pend_d[i] = pend_q[i] | evt[i];
        ovf_d[i]  = ovf_q[i] | (evt[i] & pend_q[i]);
      end
    end
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      ovf_q  <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      mask_q <= mask_d;
    end
  end

  // int_id is latched on entry to REQ and held through SERVICE: no preemption.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      int_id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
            int_id_q  <= lowest_set(elig);
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q      <= SERVICE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!elig[int_id_q]) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (int_ret) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          int_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pend_q;
  assign mask       = mask_q;
  assign overflow   = ovf_q;
  assign int_addr   = VEC_BASE + ADDR_W'(int_id_q) * ADDR_W'(VEC_STRIDE);

endmodule
